// File: rtl/contador_regresivo.sv
// Down-counter with load, enable and a one-cycle terminal-count flag (FSM: REPOSO/CONTANDO/FIN).
// Define CONTADOR_REGRESIVO_RECARGA_EN to make FIN reload MAXIMO and keep counting periodically.
module contador_regresivo #(
    parameter int ANCHO  = 4,
    parameter int MAXIMO = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cargar,
    input  logic [ANCHO-1:0] i_valor,
    input  logic             i_habilitar,
    output logic [ANCHO-1:0] o_cuenta,
    output logic             o_fin,
    output logic             o_ocupado,
    output logic [1:0]       o_estado
);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        CONTANDO = 2'd1,
        FIN      = 2'd2
    } estado_t;

    localparam logic [ANCHO-1:0] MAX_L = ANCHO'(MAXIMO);
    localparam logic [ANCHO-1:0] UNO   = ANCHO'(1);

    estado_t          estado;
    estado_t          estado_sig;
    logic [ANCHO-1:0] cuenta_sig;
    logic [ANCHO-1:0] valor_sat;

    assign valor_sat = (i_valor > MAX_L) ? MAX_L : i_valor;
    assign o_estado  = estado;

    // A load wins over counting and over leaving FIN in the same cycle.
    always_comb begin
        estado_sig = estado;
        cuenta_sig = o_cuenta;
        if (i_cargar) begin
            cuenta_sig = valor_sat;
            estado_sig = (valor_sat == '0) ? FIN : CONTANDO;
        end else begin
            case (estado)
                REPOSO: begin
                    estado_sig = REPOSO;
                end
                CONTANDO: begin
                    if (i_habilitar) begin
                        if (o_cuenta > UNO) begin
                            cuenta_sig = o_cuenta - UNO;
                        end else begin
                            cuenta_sig = '0;
                            estado_sig = FIN;
                        end
                    end
                end
                FIN: begin
`ifdef CONTADOR_REGRESIVO_RECARGA_EN
                    cuenta_sig = MAX_L;
                    estado_sig = CONTANDO;
`else
                    cuenta_sig = '0;
                    estado_sig = REPOSO;
`endif
                end
                default: begin
                    cuenta_sig = '0;
                    estado_sig = REPOSO;
                end
            endcase
        end
    end

    // Flags are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            estado    <= REPOSO;
            o_cuenta  <= '0;
            o_fin     <= 1'b0;
            o_ocupado <= 1'b0;
        end else begin
            estado    <= estado_sig;
            o_cuenta  <= cuenta_sig;
            o_fin     <= (estado_sig == FIN);
            o_ocupado <= (estado_sig != REPOSO);
        end
    end

endmodule

// File: tb/tb_contador_regresivo.sv
// Directed bench for contador_regresivo (ANCHO=4, MAXIMO=10); expectations queued per step.
module tb_contador_regresivo;

    localparam int ANCHO  = 4;
    localparam int MAXIMO = 10;
    localparam int W      = ANCHO + 2;

`ifdef CONTADOR_REGRESIVO_RECARGA_EN
    localparam logic [ANCHO-1:0] POST_FIN_CUENTA = ANCHO'(MAXIMO);
    localparam logic             POST_FIN_OCUP   = 1'b1;
`else
    localparam logic [ANCHO-1:0] POST_FIN_CUENTA = '0;
    localparam logic             POST_FIN_OCUP   = 1'b0;
`endif

    logic             i_clk;
    logic             i_rst_n;
    logic             i_cargar;
    logic [ANCHO-1:0] i_valor;
    logic             i_habilitar;
    logic [ANCHO-1:0] o_cuenta;
    logic             o_fin;
    logic             o_ocupado;
    logic [1:0]       o_estado;

    int checks_total;
    int checks_passed;

    logic [W-1:0] exp_q[$];

    contador_regresivo #(.ANCHO(ANCHO), .MAXIMO(MAXIMO)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cargar    (i_cargar),
        .i_valor     (i_valor),
        .i_habilitar (i_habilitar),
        .o_cuenta    (o_cuenta),
        .o_fin       (o_fin),
        .o_ocupado   (o_ocupado),
        .o_estado    (o_estado)
    );

    // Clock and reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int expv);
        checks_total++;
        assert (obs === expv) begin
            checks_passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [ANCHO-1:0] c,
                                 input logic f, input logic o);
        check({tag, ".cuenta"}, int'(o_cuenta), int'(c));
        check({tag, ".fin"}, int'(o_fin), int'(f));
        check({tag, ".ocupado"}, int'(o_ocupado), int'(o));
    endtask

    // Driver: called at a falling edge; drives inputs, queues expectation, samples at next falling edge.
    task automatic step(input string tag, input logic cargar, input logic [ANCHO-1:0] valor,
                        input logic hab, input logic [ANCHO-1:0] e_cuenta,
                        input logic e_fin, input logic e_ocup);
        logic [W-1:0] e;
        i_cargar    = cargar;
        i_valor     = valor;
        i_habilitar = hab;
        exp_q.push_back({e_cuenta, e_fin, e_ocup});
        @(posedge i_clk);
        @(negedge i_clk);
        if (exp_q.size() == 0) begin
            checks_total++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_outputs(tag, e[W-1:2], e[1], e[0]);
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        i_rst_n     = 1'b0;
        i_cargar    = 1'b0;
        i_valor     = '0;
        i_habilitar = 1'b0;
        #2;
        check_outputs("reset", '0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Idle ignores enable
        step("idle_hab", 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);

        // Load 7 and count down with enable high; FIN 7 edges after load
        step("load7", 1'b1, 4'd7, 1'b1, 4'd7, 1'b0, 1'b1);
        for (int k = 6; k >= 1; k--)
            step("cnt7", 1'b0, 4'd0, 1'b1, ANCHO'(k), 1'b0, 1'b1);
        step("fin7", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1);
        step("post_fin7", 1'b0, 4'd0, 1'b1, POST_FIN_CUENTA, 1'b0, POST_FIN_OCUP);

        // Load above MAXIMO saturates
        step("load15", 1'b1, 4'd15, 1'b1, 4'd10, 1'b0, 1'b1);
        for (int k = 9; k >= 1; k--)
            step("cnt10", 1'b0, 4'd0, 1'b1, ANCHO'(k), 1'b0, 1'b1);
        step("fin10", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1);

        // Enable gating: load 5 then enable 1,0,0,1
        step("load5", 1'b1, 4'd5, 1'b0, 4'd5, 1'b0, 1'b1);
        step("hab1a", 1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 1'b1);
        step("hab0a", 1'b0, 4'd0, 1'b0, 4'd4, 1'b0, 1'b1);
        step("hab0b", 1'b0, 4'd0, 1'b0, 4'd4, 1'b0, 1'b1);
        step("hab1b", 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b1);

        // Load 0 mid-count goes straight to FIN for one cycle
        step("load0", 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1);
        step("post_load0", 1'b0, 4'd0, 1'b0, POST_FIN_CUENTA, 1'b0, POST_FIN_OCUP);

        // Load during FIN beats the FIN exit
        step("load2", 1'b1, 4'd2, 1'b1, 4'd2, 1'b0, 1'b1);
        step("cnt2", 1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b1);
        step("fin2", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1);
        step("load_in_fin", 1'b1, 4'd4, 1'b1, 4'd4, 1'b0, 1'b1);

        // Reload at 3 beats decrement, then async reset mid-count
        step("load6", 1'b1, 4'd6, 1'b1, 4'd6, 1'b0, 1'b1);
        step("cnt6a", 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b1);
        step("cnt6b", 1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 1'b1);
        step("cnt6c", 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b1);
        step("reload8", 1'b1, 4'd8, 1'b1, 4'd8, 1'b0, 1'b1);
        step("cnt8", 1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b1);
        i_rst_n = 1'b0;
        #1;
        check_outputs("async_rst", '0, 1'b0, 1'b0);
        @(posedge i_clk);
        @(negedge i_clk);
        check_outputs("rst_held", '0, 1'b0, 1'b0);
        i_rst_n = 1'b1;
        step("after_rst", 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);

`ifdef CONTADOR_REGRESIVO_RECARGA_EN
        // Periodic wrap: FIN every MAXIMO+1 cycles
        step("load_max", 1'b1, 4'd10, 1'b1, 4'd10, 1'b0, 1'b1);
        for (int i = 1; i <= 30; i++) begin
            int v;
            v = MAXIMO - (i % (MAXIMO + 1));
            step("wrap", 1'b0, 4'd0, 1'b1, ANCHO'(v), (v == 0), 1'b1);
        end
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/contador_regresivo.md
CONTADOR_REGRESIVO -- requirements
Module: contador_regresivo

Interface
REQ-001 Parameter ANCHO, default 4: bit width of i_valor and o_cuenta.
REQ-002 Parameter MAXIMO, default 10: highest legal count; SHALL satisfy 1 <= MAXIMO <= 2^ANCHO-1.
REQ-003 i_clk  input  1  clock; all state changes on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_cargar  input  1  load request, sampled on rising edge.
REQ-006 i_valor  input  ANCHO  load value, sampled when i_cargar=1.
REQ-007 i_habilitar  input  1  count enable; decrement allowed when 1.
REQ-008 o_cuenta  output  ANCHO  current count, registered.
REQ-009 o_fin  output  1  terminal-count flag, registered, high exactly while FSM is in FIN.
REQ-010 o_ocupado  output  1  high while FSM is in CONTANDO or FIN, registered or decoded from state register only.

Function
REQ-011 FSM SHALL have exactly three states: REPOSO, CONTANDO, FIN.
REQ-012 Load: i_cargar=1 on an edge, in any state, SHALL set o_cuenta to min(i_valor, MAXIMO) on that edge.
REQ-013 Load of a nonzero saturated value SHALL enter CONTANDO; load of 0 SHALL enter FIN directly.
REQ-014 i_cargar SHALL take priority over i_habilitar and over any FIN exit transition in the same cycle.
REQ-015 REPOSO: o_cuenta holds its value; i_habilitar ignored.
REQ-016 CONTANDO with i_habilitar=0: o_cuenta and state hold.
REQ-017 CONTANDO with i_habilitar=1 and o_cuenta>1: o_cuenta decrements by 1 on the edge; state stays CONTANDO.
REQ-018 CONTANDO with i_habilitar=1 and o_cuenta=1: o_cuenta becomes 0 and state becomes FIN on the same edge, so o_fin rises in the cycle o_cuenta first shows 0.
REQ-019 FIN SHALL last exactly one clock cycle absent a load; exit target per REQ-024/REQ-025, independent of i_habilitar.
REQ-020 Latency: load of value N (1..MAXIMO) with i_habilitar held 1 SHALL produce o_fin=1 exactly N edges after the load edge.
REQ-021 o_cuenta SHALL never exceed MAXIMO and SHALL never underflow below 0.

Reset
REQ-022 i_rst_n=0 SHALL immediately, without a clock edge, force state REPOSO, o_cuenta=0, o_fin=0, o_ocupado=0.
REQ-023 Reset asserted mid-count or during FIN SHALL abort the operation; after deassertion the block stays in REPOSO until the next load.

Configuration
REQ-024 Macro CONTADOR_REGRESIVO_RECARGA_EN defined: FIN SHALL exit to CONTANDO with o_cuenta=MAXIMO (wrap-around 0 -> MAXIMO), giving continuous periodic o_fin pulses of period MAXIMO+1 cycles with i_habilitar=1.
REQ-025 Macro not defined: FIN SHALL exit to REPOSO with o_cuenta held at 0; o_ocupado drops on that edge.

Verification
REQ-026 Reset, load 7, i_habilitar=1 -> o_cuenta 7,6,...,1,0 on consecutive edges; o_fin=1 only in the cycle showing 0; o_fin rises 7 edges after load.
REQ-027 Load 15 with MAXIMO=10 -> o_cuenta=10 next cycle; o_fin 10 edges later.
REQ-028 Load 5, toggle i_habilitar 1,0,0,1 -> o_cuenta 4,4,4,3; o_ocupado=1 throughout.
REQ-029 Load 0 -> o_cuenta=0 and o_fin=1 next cycle for one cycle; then REPOSO without macro, o_cuenta=10 with macro.
REQ-030 In CONTANDO at o_cuenta=3, assert i_cargar=1 with i_valor=8 and i_habilitar=1 -> o_cuenta=8, not 2; then drop i_rst_n mid-count -> o_cuenta=0, o_fin=0, o_ocupado=0 immediately, with no clock edge.
REQ-031 With CONTADOR_REGRESIVO_RECARGA_EN, load 10, i_habilitar=1 for 30 cycles -> o_fin pulses every 11 cycles; o_cuenta sequence 10..0,10..0,...
